// File: rtl/ssd_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// ssd_scan_ctrl_if
//
// Bundles the data and display-side signals of the seven-segment scan
// controller so that the producer of display values and the controller share
// one connection.
//
// Signals:
//   value      [15:0] hex value to show, digit 0 in value[3:0]
//   load              single-cycle strobe capturing value
//   blank_lz          leading-zero blanking enable (live, not buffered)
//   seg        [7:0]  segment pattern for the active digit
//   ssd_ctl    [3:0]  digit enables, active low
//   frame_done        one-cycle pulse after each four-digit frame
//   pending           a loaded value is waiting for the frame boundary
//
// Modports:
//   master  drives value/load/blank_lz, observes the display outputs
//   slave   the scan controller itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ssd_scan_ctrl_if;
   logic [15:0] value;
   logic        load;
   logic        blank_lz;
   logic [7:0]  seg;
   logic [3:0]  ssd_ctl;
   logic        frame_done;
   logic        pending;

   modport master (
      output value,
      output load,
      output blank_lz,
      input  seg,
      input  ssd_ctl,
      input  frame_done,
      input  pending
   );

   modport slave (
      input  value,
      input  load,
      input  blank_lz,
      output seg,
      output ssd_ctl,
      output frame_done,
      output pending
   );
endinterface : ssd_scan_ctrl_if

// File: rtl/ssd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// ssd_scan_ctrl
//
// Time-multiplexing scan controller for a four-digit seven-segment display.
// A slot counter divides the clock into digit slots; each slot enables one
// digit (active low) and presents the matching nibble of the committed value
// to the hex decoder. New values are double-buffered and committed only at
// frame boundaries so a frame never mixes old and new digits. Optional
// leading-zero blanking turns off zero digits above the most significant
// non-zero digit; digit 0 always stays lit.
//
// Parameters:
//   DIV_MAX    slot length minus one, in clock cycles (1..65535)
//   DIV_WIDTH  width of the slot counter, 2**DIV_WIDTH > DIV_MAX
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ssd_scan_ctrl_if.slave (value/load/blank_lz in,
//          seg/ssd_ctl/frame_done/pending out)
//
// Also contains the hex-to-seven-segment decoder `display`
// (bin[3:0] -> segs[7:0], active-low segments, segs[7] is the decimal point
// and is kept off).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module display (
   input  logic [3:0] bin,
   output logic [7:0] segs
);
   // Bit order {dp, g, f, e, d, c, b, a}, 0 = segment lit.
   always_comb begin
      // NOTE: every path through a combinational block assigns its outputs;
      // the default here prevents a latch if a case item is ever missed.
      segs = 8'hFF;
      unique case (bin)
         4'h0: segs = 8'hC0;
         4'h1: segs = 8'hF9;
         4'h2: segs = 8'hA4;
         4'h3: segs = 8'hB0;
         4'h4: segs = 8'h99;
         4'h5: segs = 8'h92;
         4'h6: segs = 8'h82;
         4'h7: segs = 8'hF8;
         4'h8: segs = 8'h80;
         4'h9: segs = 8'h90;
         4'hA: segs = 8'h88;
         4'hB: segs = 8'h83;
         4'hC: segs = 8'hC6;
         4'hD: segs = 8'hA1;
         4'hE: segs = 8'h86;
         4'hF: segs = 8'h8E;
         default: segs = 8'hFF;
      endcase
   end
endmodule : display

module ssd_scan_ctrl #(
   parameter int unsigned DIV_MAX   = 49999,
   parameter int unsigned DIV_WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   ssd_scan_ctrl_if.slave      bus
);

   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DIV_WIDTH-1:0] cnt;          // position inside the current slot
   logic [1:0]           idx;          // digit currently being driven
   logic [15:0]          disp;         // value shown this frame
   logic [15:0]          pend_val;     // value waiting for the next boundary
   logic                 pending_q;
   logic                 frame_done_q;

   logic tick;   // last cycle of a digit slot
   logic fb;     // last cycle of a frame

   assign tick = (cnt == DIV_LAST);
   assign fb   = tick && (idx == 2'd3);

   // ---------------------------------------------------------------------------
   // Slot counter, digit rotation, double buffer and frame pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         idx          <= 2'd0;
         disp         <= 16'h0000;
         pend_val     <= 16'h0000;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register here samples the pre-edge values (fb, pending_q, idx)
         // regardless of statement order.
         frame_done_q <= fb;

         if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + DIV_ONE;
         end

         // A load on the boundary cycle goes straight to the display; any
         // older pending value is dropped because it would be overwritten
         // before it could ever be shown.
         if (bus.load && fb) begin
            disp      <= bus.value;
            pending_q <= 1'b0;
         end else if (bus.load) begin
            pend_val  <= bus.value;
            pending_q <= 1'b1;
         end else if (fb && pending_q) begin
            disp      <= pend_val;
            pending_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Nibble select and decode
   // ---------------------------------------------------------------------------
   logic [3:0] nibble;

   assign nibble = disp[{idx, 2'b00} +: 4];

   display u_display (
      .bin  (nibble),
      .segs (bus.seg)
   );

   // ---------------------------------------------------------------------------
   // Leading-zero blanking and digit enables
   //
   // Slot k is blanked when every digit from k upward is zero. Digit 0 is
   // never blanked so an all-zero value still shows a single "0". blank_lz is
   // deliberately not registered: it acts on ssd_ctl in the same cycle.
   // ---------------------------------------------------------------------------
   logic       blank;
   logic [3:0] enables;

   always_comb begin
      blank = 1'b0;
      unique case (idx)
         2'd0: blank = 1'b0;
         2'd1: blank = (disp[15:4]  == 12'h000);
         2'd2: blank = (disp[15:8]  == 8'h00);
         2'd3: blank = (disp[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end

   always_comb begin
      enables = 4'b1111;
      unique case (idx)
         2'd0: enables = 4'b1110;
         2'd1: enables = 4'b1101;
         2'd2: enables = 4'b1011;
         2'd3: enables = 4'b0111;
         default: enables = 4'b1111;
      endcase
   end

   assign bus.ssd_ctl    = (bus.blank_lz && blank) ? 4'b1111 : enables;
   assign bus.frame_done = frame_done_q;
   assign bus.pending    = pending_q;

   // ---------------------------------------------------------------------------
   // Structural properties
   // ---------------------------------------------------------------------------
   // At most one digit is ever enabled.
   assert property (@(posedge clk) disable iff (!rst_n)
      (bus.ssd_ctl == 4'b1111) || $onehot(~bus.ssd_ctl));

   // The slot counter never leaves its range.
   assert property (@(posedge clk) disable iff (!rst_n)
      cnt <= DIV_LAST);

endmodule : ssd_scan_ctrl
